// File: rtl/bmem_arb_pkg.sv
// bmem_arb_pkg: shared constants and types for the banked-memory port arbiter
package bmem_arb_pkg;
    localparam int BURST_LEN = 4;
    localparam int LINE_AW = 32;
    localparam int OWNER_W = 4;
    localparam int BEATS_W = 8;
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } arb_state_t;
    typedef struct packed {
        logic               valid;
        logic [LINE_AW-1:0] addr;
        logic [OWNER_W-1:0] owner;
        logic [BEATS_W-1:0] beats;
    } rtable_entry_t;
    function automatic logic [BEATS_W-1:0] last_beat(input int len);
        return BEATS_W'(len - 1);
    endfunction
endpackage

// File: rtl/bmem_arb_rtable.sv
// bmem_arb_rtable: outstanding-read table mapping in-flight line addresses to their requester
module bmem_arb_rtable
    import bmem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int OUTSTANDING = 4,
    parameter int BURST_LEN   = bmem_arb_pkg::BURST_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0][LINE_AW-1:0] i_query_addr,
    output logic [NUM_REQ-1:0]              o_dup_hit,
    output logic                            o_full,
    input  logic                            i_alloc,
    input  logic [LINE_AW-1:0]              i_alloc_addr,
    input  logic [OWNER_W-1:0]              i_alloc_owner,
    input  logic                            i_rvalid,
    input  logic [LINE_AW-1:0]              i_raddr,
    output logic                            o_hit,
    output logic [OWNER_W-1:0]              o_hit_owner
);
    localparam int IDX_W = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;

    rtable_entry_t          r_tab [OUTSTANDING];
    logic [OUTSTANDING-1:0] w_free;
    logic [OUTSTANDING-1:0] w_hit;
    logic [IDX_W-1:0]       w_alloc_idx;
    logic [IDX_W-1:0]       w_hit_idx;

    // Scan downwards so the lowest free slot and the matching slot win
    always_comb begin
        w_alloc_idx = '0;
        w_hit_idx = '0;
        for (int k = OUTSTANDING - 1; k >= 0; k--) begin
            w_free[k] = !r_tab[k].valid;
            w_hit[k] = r_tab[k].valid && r_tab[k].addr == i_raddr;
            if (w_free[k]) w_alloc_idx = IDX_W'(k);
            if (w_hit[k]) w_hit_idx = IDX_W'(k);
        end
    end

    // A requester's read is blocked while any live entry already tracks its line
    always_comb begin
        o_dup_hit = '0;
        for (int q = 0; q < NUM_REQ; q++)
            for (int k = 0; k < OUTSTANDING; k++)
                if (r_tab[k].valid && r_tab[k].addr == i_query_addr[q]) o_dup_hit[q] = 1'b1;
    end

    assign o_full = ~|w_free;
    assign o_hit = i_rvalid && |w_hit;
    assign o_hit_owner = r_tab[w_hit_idx].owner;

    // Allocate on a read grant; count returning beats and free the entry after the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < OUTSTANDING; k++) r_tab[k] <= '0;
        end else begin
            if (i_alloc) r_tab[w_alloc_idx] <= '{valid: 1'b1, addr: i_alloc_addr, owner: i_alloc_owner, beats: BEATS_W'(0)};
            if (o_hit) begin
                if (r_tab[w_hit_idx].beats == last_beat(BURST_LEN)) r_tab[w_hit_idx].valid <= 1'b0;
                else r_tab[w_hit_idx].beats <= r_tab[w_hit_idx].beats + 1'b1;
            end
        end
    end
endmodule

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: round-robin sharing of the bmem line port with write-burst locking and read steering
module bmem_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int OUTSTANDING = 4,
    parameter int BURST_LEN   = bmem_arb_pkg::BURST_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0][31:0] req_addr,
    input  logic [NUM_REQ-1:0]       req_read,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0][63:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0][31:0] resp_raddr,
    output logic [NUM_REQ-1:0][63:0] resp_rdata,
    output logic [NUM_REQ-1:0]       resp_rvalid,
    output logic [31:0]              bmem_addr,
    output logic                     bmem_read,
    output logic                     bmem_write,
    output logic [63:0]              bmem_wdata,
    input  logic                     bmem_ready,
    input  logic [31:0]              bmem_raddr,
    input  logic [63:0]              bmem_rdata,
    input  logic                     bmem_rvalid,
    output logic                     err
);
    localparam int PTR_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    arb_state_t         r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [BEATS_W-1:0] r_beat_cnt;
    logic               r_err;
    logic [NUM_REQ-1:0] w_dup;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_full;
    logic               w_found;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_sel;
    logic               w_grant;
    logic               w_wr_grant;
    logic               w_rd_grant;
    logic               w_accept;
    logic               w_hit;
    logic [OWNER_W-1:0] w_hit_owner;
    logic [PTR_W-1:0]   w_hit_sel;

    bmem_arb_rtable #(
        .NUM_REQ    (NUM_REQ),
        .OUTSTANDING(OUTSTANDING),
        .BURST_LEN  (BURST_LEN)
    ) u_rtable (
        .clk          (clk),
        .rst          (rst),
        .i_query_addr (req_addr),
        .o_dup_hit    (w_dup),
        .o_full       (w_full),
        .i_alloc      (w_rd_grant),
        .i_alloc_addr (req_addr[w_win]),
        .i_alloc_owner(OWNER_W'(w_win)),
        .i_rvalid     (bmem_rvalid),
        .i_raddr      (bmem_raddr),
        .o_hit        (w_hit),
        .o_hit_owner  (w_hit_owner)
    );

    // Writes are always eligible; reads need a free slot and no in-flight copy of the line
    assign w_elig = req_write | (req_read & ~w_dup & {NUM_REQ{!w_full}});

    // Walk from the far end back to rr_ptr so the first eligible requester at or after it wins
    always_comb begin
        w_found = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
            if (w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Grants are held off during reset so the port goes quiet immediately
    assign w_grant = !rst && r_state == IDLE && w_found && bmem_ready;
    assign w_wr_grant = w_grant && req_write[w_win];
    assign w_rd_grant = w_grant && !req_write[w_win];
    assign w_sel = r_state == WBURST ? r_owner : (w_grant ? w_win : PTR_W'(0));
    assign w_accept = r_state == WBURST ? bmem_ready : w_grant;
    assign bmem_addr = req_addr[w_sel];
    assign bmem_wdata = req_wdata[w_sel];
    assign bmem_read = w_rd_grant;
    assign bmem_write = r_state == WBURST || w_wr_grant;
    assign req_ready = w_accept ? NUM_REQ'(1) << w_sel : '0;
    assign w_hit_sel = PTR_W'(w_hit_owner);
    assign err = r_err;

    // Burst FSM and round-robin pointer; the pointer only moves on an IDLE grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr <= '0;
            r_owner <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_grant) r_ptr <= w_win == PTR_W'(NUM_REQ - 1) ? PTR_W'(0) : w_win + 1'b1;
            if (w_wr_grant) begin
                r_state <= WBURST;
                r_owner <= w_win;
                r_beat_cnt <= BEATS_W'(1);
            end
        end else if (bmem_ready) begin
            r_state <= r_beat_cnt == last_beat(BURST_LEN) ? IDLE : WBURST;
            r_beat_cnt <= r_beat_cnt == last_beat(BURST_LEN) ? BEATS_W'(0) : r_beat_cnt + 1'b1;
        end
    end

    // Sticky error on a response with no table entry or a write request dropped mid-burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else if ((bmem_rvalid && !w_hit) || (r_state == WBURST && !req_write[r_owner])) r_err <= 1'b1;
    end

    // Register each hit beat toward its owner one cycle after memory presents it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rvalid <= '0;
            resp_raddr <= '0;
            resp_rdata <= '0;
        end else begin
            resp_rvalid <= w_hit ? NUM_REQ'(1) << w_hit_sel : '0;
            if (w_hit) begin
                resp_raddr[w_hit_sel] <= bmem_raddr;
                resp_rdata[w_hit_sel] <= bmem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter: randomized scoreboard bench for bmem_arbiter against a queue-based reference model
module tb_bmem_arbiter;
    localparam int NR = 2;
    localparam int OS = 4;
    localparam int BL = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0][31:0] req_addr;
    logic [NR-1:0]     req_read;
    logic [NR-1:0]     req_write;
    logic [NR-1:0][63:0] req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0][31:0] resp_raddr;
    logic [NR-1:0][63:0] resp_rdata;
    logic [NR-1:0]     resp_rvalid;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [63:0]       bmem_wdata;
    logic              bmem_ready;
    logic [31:0]       bmem_raddr;
    logic [63:0]       bmem_rdata;
    logic              bmem_rvalid;
    logic              err;

    bmem_arbiter #(.NUM_REQ(NR), .OUTSTANDING(OS), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_read(req_read), .req_write(req_write), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .resp_raddr(resp_raddr), .resp_rdata(resp_rdata), .resp_rvalid(resp_rvalid),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
        .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int c; int own; logic [31:0] a; logic [63:0] d; } exp_t;
    typedef struct { logic [31:0] a; int own; int beats; } ent_t;

    exp_t        sb[$];
    ent_t        tab[$];
    logic [31:0] memq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rk [NR];
    logic [31:0] ra [NR];
    int          rb [NR];
    logic [63:0] rwd [NR][BL];
    int          ptr = 0;
    int          bown = -1;
    int          mbeat = -1;
    logic [31:0] mcur = '0;
    bit          merr = 1'b0;
    int          p_req = 0;
    int          p_wr = 0;
    int          p_rdy = 100;
    int          p_mem = 100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mdata(input logic [31:0] a, input int b);
        return {a, 32'hC0DE0000 + 32'(b)};
    endfunction

    function automatic bit inflight(input logic [31:0] a);
        foreach (tab[i]) if (tab[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit busy();
        return tab.size() > 0 || bown >= 0 || rk[0] != 0 || rk[1] != 0 || memq.size() > 0 || mbeat >= 0;
    endfunction

    // One clock of stimulus: drive requesters and memory, predict the port, then advance the model
    task automatic step(input bit stray = 1'b0);
        int g;
        int rr;
        int hi;
        int mi;
        logic [NR-1:0] e_rdy;
        logic e_rd;
        logic e_wr;
        logic [31:0] e_addr;
        logic [63:0] e_wd;
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            if (rk[r] == 0 && int'($urandom_range(99)) < p_req) begin
                rk[r] = int'($urandom_range(99)) < p_wr ? 2 : 1;
                ra[r] = 32'h1000 + 32'($urandom_range(7)) * 32'h20;
                rb[r] = 0;
                for (int b = 0; b < BL; b++) rwd[r][b] = {$urandom, $urandom};
            end
            req_read[r] = rk[r] == 1;
            req_write[r] = rk[r] == 2;
            req_addr[r] = ra[r];
            req_wdata[r] = rk[r] == 2 ? rwd[r][rb[r]] : 64'h0;
        end
        bmem_rvalid = 1'b0;
        bmem_raddr = 32'h0;
        bmem_rdata = 64'h0;
        if (stray) begin
            bmem_rvalid = 1'b1;
            bmem_raddr = 32'hDEAD0000;
            bmem_rdata = 64'hBAD0BAD0;
        end else begin
            if (mbeat < 0 && memq.size() > 0 && int'($urandom_range(99)) < p_mem) begin
                mi = int'($urandom_range(memq.size() - 1));
                mcur = memq[mi];
                memq.delete(mi);
                mbeat = 0;
            end
            if (mbeat >= 0) begin
                bmem_rvalid = 1'b1;
                bmem_raddr = mcur;
                bmem_rdata = mdata(mcur, mbeat);
            end
        end
        bmem_ready = int'($urandom_range(99)) < p_rdy;
        #1;
        g = -1;
        e_rdy = '0;
        e_rd = 1'b0;
        e_wr = 1'b0;
        e_addr = req_addr[0];
        e_wd = req_wdata[0];
        if (bown >= 0) begin
            e_wr = 1'b1;
            e_addr = ra[bown];
            e_wd = rwd[bown][rb[bown]];
            if (bmem_ready) e_rdy = NR'(1) << bown;
        end else if (bmem_ready) begin
            for (int i = 0; i < NR; i++) begin
                rr = (ptr + i) % NR;
                if (g < 0 && (rk[rr] == 2 || (rk[rr] == 1 && tab.size() < OS && !inflight(ra[rr])))) g = rr;
            end
            if (g >= 0) begin
                e_rdy = NR'(1) << g;
                e_rd = rk[g] == 1;
                e_wr = rk[g] == 2;
                e_addr = ra[g];
                e_wd = req_wdata[g];
            end
        end
        chk("req_ready", req_ready, e_rdy);
        chk("bmem_read", bmem_read, e_rd);
        chk("bmem_write", bmem_write, e_wr);
        chk("bmem_addr", bmem_addr, e_addr);
        chk("bmem_wdata", bmem_wdata, e_wd);
        chk("err", err, merr);
        if (bown >= 0) begin
            if (bmem_ready) begin
                rb[bown]++;
                if (rb[bown] == BL) begin
                    rk[bown] = 0;
                    bown = -1;
                end
            end
        end else if (g >= 0) begin
            ptr = (g + 1) % NR;
            if (rk[g] == 1) begin
                tab.push_back('{a: ra[g], own: g, beats: 0});
                memq.push_back(ra[g]);
                rk[g] = 0;
            end else begin
                rb[g] = 1;
                bown = g;
            end
        end
        if (bmem_rvalid) begin
            hi = -1;
            foreach (tab[i]) if (tab[i].a == bmem_raddr) hi = i;
            if (hi < 0) merr = 1'b1;
            else begin
                sb.push_back('{c: cyc + 1, own: tab[hi].own, a: bmem_raddr, d: bmem_rdata});
                tab[hi].beats++;
                if (tab[hi].beats == BL) tab.delete(hi);
            end
            if (!stray) begin
                mbeat++;
                if (mbeat == BL) mbeat = -1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        p_req = 0;
        p_mem = 100;
        p_rdy = 100;
        while (busy() && n < 400) begin
            step();
            n++;
        end
        chk("drain_in_time", n < 400, 1'b1);
        repeat (2) step();
    endtask

    // Monitor: every response beat must match the oldest expected beat, in the predicted cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (resp_rvalid != '0) begin
                chk("resp_onehot", $countones(resp_rvalid), 1);
                if (sb.size() == 0) chk("resp_unexpected", resp_rvalid, 64'h0);
                else begin
                    e = sb.pop_front();
                    chk("resp_cycle", cyc, e.c);
                    chk("resp_owner", resp_rvalid, NR'(1) << e.own);
                    chk("resp_raddr", resp_raddr[e.own], e.a);
                    chk("resp_rdata", resp_rdata[e.own], e.d);
                end
            end else if (sb.size() > 0 && sb[0].c <= cyc) begin
                chk("resp_missing", resp_rvalid, NR'(1) << sb[0].own);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        for (int r = 0; r < NR; r++) begin
            rk[r] = 0;
            ra[r] = 32'h0;
            rb[r] = 0;
            for (int b = 0; b < BL; b++) rwd[r][b] = 64'h0;
        end
        req_addr = '0;
        req_read = '0;
        req_write = '0;
        req_wdata = '0;
        bmem_ready = 1'b0;
        bmem_raddr = '0;
        bmem_rdata = '0;
        bmem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_resp_rvalid", resp_rvalid, 64'h0);
        chk("rst_resp_rdata", resp_rdata[0], 64'h0);
        chk("rst_err", err, 64'h0);
        chk("rst_bmem_read", bmem_read, 64'h0);
        chk("rst_bmem_write", bmem_write, 64'h0);
        chk("rst_req_ready", req_ready, 64'h0);
        rst = 1'b0;
        rk[0] = 1;
        ra[0] = 32'h1000;
        repeat (12) step();
        rk[0] = 1;
        ra[0] = 32'h1000;
        rk[1] = 1;
        ra[1] = 32'h1020;
        repeat (14) step();
        rk[1] = 2;
        ra[1] = 32'h2000;
        rb[1] = 0;
        for (int b = 0; b < BL; b++) rwd[1][b] = {32'h20000000, 32'(b)};
        rk[0] = 1;
        ra[0] = 32'h1040;
        repeat (14) step();
        p_mem = 0;
        rk[0] = 1;
        ra[0] = 32'h3000;
        step();
        rk[1] = 1;
        ra[1] = 32'h3000;
        repeat (4) step();
        p_mem = 100;
        repeat (14) step();
        p_mem = 0;
        p_req = 100;
        p_wr = 0;
        repeat (20) step();
        drain();
        p_req = 40;
        p_wr = 30;
        p_rdy = 80;
        p_mem = 40;
        repeat (3000) step();
        drain();
        step(1'b1);
        repeat (3) step();
        rk[1] = 2;
        ra[1] = 32'h2040;
        rb[1] = 0;
        for (int b = 0; b < BL; b++) rwd[1][b] = {32'h20400000, 32'(b)};
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("rstasync_bmem_write", bmem_write, 64'h0);
        chk("rstasync_req_ready", req_ready, 64'h0);
        chk("rstasync_err", err, 64'h0);
        chk("rstasync_resp_rvalid", resp_rvalid, 64'h0);
        req_read = '0;
        req_write = '0;
        bmem_ready = 1'b0;
        bmem_rvalid = 1'b0;
        sb.delete();
        tab.delete();
        memq.delete();
        mbeat = -1;
        bown = -1;
        ptr = 0;
        merr = 1'b0;
        for (int r = 0; r < NR; r++) rk[r] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rk[0] = 1;
        ra[0] = 32'h1000;
        repeat (12) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
